multi_cycle_core: RTL and testbench
===================================

MULTI_CYCLE_CORE -- requirements
Module: multi_cycle_core

Interface
REQ-001 RESET_PC, 32'h0000_0000: PC value loaded on reset.
REQ-002 ADDR_W, 32: width of mem_addr; PC and ALU results truncated to ADDR_W LSBs on output.
REQ-003 clk input 1: single clock; all state changes on rising edge.
REQ-004 rst input 1: asynchronous, active-low reset.
REQ-005 mem_req output 1: memory transaction request; held until accepted.
REQ-006 mem_we output 1: 1 = store, 0 = read (fetch or load); valid while mem_req=1.
REQ-007 mem_addr output ADDR_W: byte address; valid while mem_req=1.
REQ-008 mem_wdata output 32: store data; valid while mem_req=1 and mem_we=1.
REQ-009 mem_rdata input 32: read data; sampled on the edge where mem_req=1 and mem_ready=1.
REQ-010 mem_ready input 1: transaction completes on any edge with mem_req=1 and mem_ready=1; may be high combinationally in the request cycle (zero wait).
REQ-011 halted output 1: core stopped in TRAP.
REQ-012 instret output 32: count of retired instructions.

Function
REQ-013 Unified memory port; fetch, load, store share it; at most one transaction outstanding.
REQ-014 FSM states: FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-015 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on accept, IR<=mem_rdata, go DECODE; else stay.
REQ-016 DECODE: A<=x[rs1], B<=x[rs2], immediate decoded (I, S, B, J types), go EXEC; unsupported opcode/funct goes TRAP.
REQ-017 Supported: R add/sub/and/or/slt; I addi/andi/ori/slti; lw; sw; beq; bne; jal; anything else is illegal.
REQ-018 EXEC R/I: ALUOut<=result, go WB.
REQ-019 EXEC lw/sw: ALUOut<=A+imm, go MEM.
REQ-020 EXEC beq/bne: taken -> PC<=PC+immB; not taken -> PC<=PC+4; instret++; go FETCH.
REQ-021 EXEC jal: ALUOut<=PC+4, PC<=PC+immJ, go WB.
REQ-022 Any new PC with bit1 or bit0 set: PC unchanged, go TRAP, no register write, no instret increment.
REQ-023 lw or sw effective address with [1:0]!=0: go TRAP without issuing mem_req.
REQ-024 MEM: mem_req=1, mem_addr=ALUOut, mem_we=1 for sw (mem_wdata=B).
REQ-025 MEM stall: stay in MEM until accept.
REQ-026 MEM lw accept: MDR<=mem_rdata, go WB.
REQ-027 MEM sw accept: PC<=PC+4, instret++, go FETCH.
REQ-028 WB: x[rd]<=(lw ? MDR : ALUOut); PC<=PC+4 except jal (already updated); instret++; go FETCH.
REQ-029 x0 reads 0 always; writes to x0 discarded.
REQ-030 Arithmetic modulo 2^32; slt/slti signed; immediates sign-extended to 32 bits.
REQ-031 Zero-wait cycle counts: ALU/jal 4, lw 5, sw 4, branch 3.
REQ-032 mem_req SHALL be 0 in DECODE, EXEC, WB, TRAP.
REQ-033 mem_addr, mem_we and mem_wdata SHALL stay stable while mem_req=1 and mem_ready=0.
REQ-034 TRAP is absorbing: halted=1, no memory requests, state held until reset.
REQ-035 instret wraps 32'hFFFF_FFFF -> 0.

Reset
REQ-036 rst=0 asynchronously forces state FETCH, PC=RESET_PC, mem_req=0, halted=0, instret=0, x1..x31=0, IR/A/B/ALUOut/MDR=0.
REQ-037 Reset asserted mid-transaction aborts it immediately; no register, PC or instret update from that transaction.
REQ-038 First mem_req (addr RESET_PC) is issued in the first cycle after rst deasserts.

Verification
REQ-039 Memory {addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; slt x4,x2,x1}, zero wait -> x3=2, x4=1, instret=4 after 16 cycles.
REQ-040 sw x1,8(x0) then lw x5,8(x0), 3-cycle mem_ready delay -> word 8 holds 5, x5=5, request signals stable during stall.
REQ-041 beq x0,x0,-8 at PC=0x10 -> next fetch at 0x08; bne x0,x0,+8 -> next fetch at PC+4.
REQ-042 jal x1,+12 at 0x20 -> x1=0x24, next fetch 0x2C; jal x0 leaves x0=0.
REQ-043 Illegal word 32'hFFFF_FFFF, or lw with address 0x6 -> halted=1, mem_req stays 0, instret frozen.
REQ-044 rst pulled low while in MEM with mem_ready=0 -> mem_req drops same cycle; after release, fetch from RESET_PC, instret=0.

Source files
------------

// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32I-subset core (add/sub/and/or/slt, addi/andi/ori/slti, lw, sw, beq, bne, jal)
// sharing one memory port. Illegal opcodes and misaligned targets or addresses halt the core in TRAP.
module multi_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [31:0]       instret
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [31:0] alu_q, alu_d, mdr_q, mdr_d, instret_q, instret_d;
  logic [31:0] x_q [32];
  logic        rf_we;
  logic [31:0] rf_wdata;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  logic alu_f3_ok, is_r, is_i, is_lw, is_sw, is_br, is_jal, legal;

  always_comb begin
    alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                (funct3 == 3'b110) || (funct3 == 3'b010);
    is_r   = (opcode == OP_R) &&
             (((funct7 == 7'b0000000) && alu_f3_ok) ||
              ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
    is_i   = (opcode == OP_I) && alu_f3_ok;
    is_lw  = (opcode == OP_LW) && (funct3 == 3'b010);
    is_sw  = (opcode == OP_SW) && (funct3 == 3'b010);
    is_br  = (opcode == OP_BR) && ((funct3 == 3'b000) || (funct3 == 3'b001));
    is_jal = (opcode == OP_JAL);
    legal  = is_r || is_i || is_lw || is_sw || is_br || is_jal;
  end

  logic [31:0] imm_i, imm_s, imm_b, imm_j, alu_b, alu_res;
  logic [31:0] pc_plus4, eff_addr, br_target, jal_target;
  logic        br_taken;

  always_comb begin
    imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    alu_b   = is_r ? b_q : imm_q;
    alu_res = a_q + alu_b;
    case (funct3)
      3'b111:  alu_res = a_q & alu_b;
      3'b110:  alu_res = a_q | alu_b;
      3'b010:  alu_res = {31'b0, $signed(a_q) < $signed(alu_b)};
      default: alu_res = (is_r && funct7[5]) ? (a_q - alu_b) : (a_q + alu_b);
    endcase

    pc_plus4   = pc_q + 32'd4;
    eff_addr   = a_q + imm_q;
    br_taken   = (a_q == b_q) ^ funct3[0];
    br_target  = br_taken ? (pc_q + imm_q) : pc_plus4;
    jal_target = pc_q + imm_q;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    instret_d = instret_q;
    rf_we     = 1'b0;
    rf_wdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      S_FETCH: begin
        // gated by rst so the request drops the instant reset asserts
        mem_req  = rst;
        mem_addr = pc_q[ADDR_W-1:0];
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = (rs1 == 5'd0) ? '0 : x_q[rs1];
        b_d = (rs2 == 5'd0) ? '0 : x_q[rs2];
        if (is_sw)       imm_d = imm_s;
        else if (is_br)  imm_d = imm_b;
        else if (is_jal) imm_d = imm_j;
        else             imm_d = imm_i;
        state_d = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (is_r || is_i) begin
          alu_d   = alu_res;
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          alu_d   = eff_addr;
          state_d = (eff_addr[1:0] != 2'b00) ? S_TRAP : S_MEM;
        end else if (is_br) begin
          if (br_target[1:0] != 2'b00) begin
            state_d = S_TRAP;
          end else begin
            pc_d      = br_target;
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
          end
        end else if (jal_target[1:0] != 2'b00) begin
          state_d = S_TRAP;
        end else begin
          alu_d   = pc_plus4;
          pc_d    = jal_target;
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req   = rst;
        mem_we    = is_sw;
        mem_addr  = alu_q[ADDR_W-1:0];
        mem_wdata = b_q;
        if (mem_ready) begin
          if (is_sw) begin
            pc_d      = pc_plus4;
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we     = (rd != 5'd0);
        rf_wdata  = is_lw ? mdr_q : alu_q;
        pc_d      = is_jal ? pc_q : pc_plus4;
        instret_d = instret_q + 32'd1;
        state_d   = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      instret_q <= instret_d;
    end
  end

  // x0 is never written, so it reads back zero from reset onward
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) x_q[i] <= '0;
    end else if (rf_we) begin
      x_q[rd] <= rf_wdata;
    end
  end

  assign halted  = (state_q == S_TRAP);
  assign instret = instret_q;

endmodule

// File: tb/tb_multi_cycle_core.sv
// Bench for multi_cycle_core: a memory model with programmable wait states, and a scoreboard of
// expected bus transactions checked by a monitor on every cycle that mem_req is high.
module tb_multi_cycle_core;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, instret;

  logic [31:0] mem [64];
  txn_t        exp_q [$];
  int          wait_cfg, wait_cnt;
  int          checks = 0;
  int          errors = 0;

  multi_cycle_core #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic exp_rd(input logic [31:0] a);
    exp_q.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{we: 1'b1, addr: a, wdata: d});
  endtask

  // Memory responder: decides mem_ready on the falling edge, completes on the next rising edge.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (!(rst === 1'b1 && mem_req === 1'b1)) begin
      wait_cnt = 0;
    end else if (wait_cnt >= wait_cfg) begin
      mem_ready = 1'b1;
      wait_cnt  = 0;
      if (mem_we) mem[mem_addr[7:2]] = mem_wdata;
      else        mem_rdata = mem[mem_addr[7:2]];
    end else begin
      wait_cnt++;
    end
  end

  // Monitor: every requesting cycle must match the scoreboard head; pop on completion.
  txn_t e;
  always @(negedge clk) begin
    #2;
    if (rst === 1'b1 && mem_req === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_txn at %0t: got addr %h we %b expected no request",
                 $time, mem_addr, mem_we);
      end else begin
        e = exp_q[0];
        chk("txn_we", {31'b0, mem_we}, {31'b0, e.we});
        chk("txn_addr", mem_addr, e.addr);
        if (e.we) chk("txn_wdata", mem_wdata, e.wdata);
        if (mem_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic start_test(input int wcfg);
    rst = 1'b0;
    exp_q.delete();
    wait_cfg = wcfg;
    for (int i = 0; i < 64; i++) mem[i] = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_instret", instret, 32'd0);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("first_req", {31'b0, mem_req}, 32'd1);
    chk("first_addr", mem_addr, 32'h0000_0000);
  endtask

  task automatic wait_halt(input logic [31:0] exp_ir);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("halt_reached", {31'b0, halted}, 32'd1);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("instret", instret, exp_ir);
    repeat (5) begin
      @(negedge clk);
      chk("trap_no_req", {31'b0, mem_req}, 32'd0);
    end
    chk("instret_frozen", instret, exp_ir);
  endtask

  logic [31:0] a_vals [9];

  initial begin
    rst       = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    wait_cfg  = 0;
    wait_cnt  = 0;

    // ALU program, zero wait: results stored to 0x80.. for checking
    start_test(0);
    mem[0]  = enc_i(12'd5,   5'd0, 3'b000, 5'd1, OP_I);
    mem[1]  = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, OP_I);
    mem[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    mem[3]  = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd4);
    mem[4]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd5);
    mem[5]  = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd6);
    mem[6]  = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd7);
    mem[7]  = enc_i(12'd0,   5'd2, 3'b010, 5'd8, OP_I);
    mem[8]  = enc_i(12'h0F0, 5'd2, 3'b111, 5'd9, OP_I);
    mem[9]  = enc_i(12'hFF0, 5'd1, 3'b110, 5'd10, OP_I);
    mem[10] = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd11);
    a_vals = '{32'd2, 32'd1, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'd1, 32'h0000_00F0,
               32'hFFFF_FFF5, 32'd0};
    for (int i = 0; i < 11; i++) exp_rd(32'(4 * i));
    for (int k = 0; k < 9; k++) begin
      mem[11 + k] = enc_s(12'(32'h80 + 4 * k), 5'(3 + k), 5'd0);
      exp_rd(32'(4 * (11 + k)));
      exp_wr(32'(32'h80 + 4 * k), a_vals[k]);
    end
    exp_rd(32'h50);
    release_rst();
    repeat (15) @(posedge clk);
    #1 chk("instret_edge15", instret, 32'd3);
    @(posedge clk);
    #1 chk("instret_edge16", instret, 32'd4);
    wait_halt(32'd20);

    // sw/lw through word 8 with 3 wait states; jal x0 hops over the data word
    start_test(3);
    mem[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_I);
    mem[1]  = enc_j(21'h3C, 5'd0);
    mem[16] = enc_s(12'h008, 5'd1, 5'd0);
    mem[17] = enc_i(12'd8, 5'd0, 3'b010, 5'd5, OP_LW);
    mem[18] = enc_s(12'h084, 5'd5, 5'd0);
    mem[19] = enc_s(12'h088, 5'd0, 5'd0);
    exp_rd(32'h00); exp_rd(32'h04); exp_rd(32'h40); exp_wr(32'h08, 32'd5);
    exp_rd(32'h44); exp_rd(32'h08); exp_rd(32'h48); exp_wr(32'h84, 32'd5);
    exp_rd(32'h4C); exp_wr(32'h88, 32'd0); exp_rd(32'h50);
    release_rst();
    wait_halt(32'd6);
    chk("word8", mem[2], 32'd5);

    // branches and jal
    start_test(0);
    mem[0]  = enc_j(21'h10, 5'd0);
    mem[4]  = enc_b(13'h1FF8, 3'b000, 5'd0, 5'd0);
    mem[2]  = enc_j(21'h18, 5'd0);
    mem[8]  = enc_j(21'd12, 5'd1);
    mem[11] = enc_b(13'd8, 3'b001, 5'd0, 5'd0);
    mem[12] = enc_b(13'd8, 3'b001, 5'd1, 5'd0);
    mem[14] = enc_s(12'h080, 5'd1, 5'd0);
    mem[15] = enc_b(13'd8, 3'b000, 5'd1, 5'd0);
    exp_rd(32'h00); exp_rd(32'h10); exp_rd(32'h08); exp_rd(32'h20); exp_rd(32'h2C);
    exp_rd(32'h30); exp_rd(32'h38); exp_wr(32'h80, 32'h24); exp_rd(32'h3C); exp_rd(32'h40);
    release_rst();
    wait_halt(32'd8);

    // illegal word at reset PC
    start_test(0);
    exp_rd(32'h00);
    release_rst();
    wait_halt(32'd0);

    // misaligned load address traps before any data request
    start_test(0);
    mem[0] = enc_i(12'd6, 5'd0, 3'b010, 5'd5, OP_LW);
    exp_rd(32'h00);
    release_rst();
    wait_halt(32'd0);

    // misaligned jump target
    start_test(1);
    mem[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1, OP_I);
    mem[1] = enc_j(21'd6, 5'd0);
    exp_rd(32'h00); exp_rd(32'h04);
    release_rst();
    wait_halt(32'd1);

    // reset while a load is stalled in MEM
    start_test(0);
    mem[0]  = enc_i(12'h080, 5'd0, 3'b010, 5'd5, OP_LW);
    mem[32] = 32'h0000_1234;
    exp_rd(32'h00); exp_rd(32'h80);
    release_rst();
    @(posedge clk);
    #1 wait_cfg = 1000;
    repeat (3) @(posedge clk);
    #3;
    chk("stall_req", {31'b0, mem_req}, 32'd1);
    chk("stall_addr", mem_addr, 32'h80);
    rst = 1'b0;
    #1;
    chk("abort_req_drop", {31'b0, mem_req}, 32'd0);
    chk("abort_instret", instret, 32'd0);
    exp_q.delete();
    wait_cfg = 0;
    exp_rd(32'h00); exp_rd(32'h80); exp_rd(32'h04);
    release_rst();
    chk("restart_instret", instret, 32'd0);
    wait_halt(32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
